// File: rtl/enc_pkg.sv
// Shared types and field positions for the 9-bit machine-code write path.
//   enc_kind_t : which packing layout applies to a decoded field bundle
//   state_t    : loader session state
package enc_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned WORD_W = 9;

    // Opcode always occupies the top three bits of the word.
    localparam int unsigned OP_MSB = 8;
    localparam int unsigned OP_LSB = 6;

    typedef enum logic [1:0] {
        KindReg    = 2'd0,
        KindAdd    = 2'd1,
        KindShift  = 2'd2,
        KindBranch = 2'd3
    } enc_kind_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } state_t;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: decoded instruction fields -> 9-bit machine word.
// The layout is the exact inverse of the register-select decode.
// Ports:
//   kind    : layout selector (REG/ADD/SHIFT/BRANCH)
//   op      : opcode, always word[8:6]
//   ra      : reg A (bit 3 meaningful only for ADD)
//   rb      : reg B / branch flag select
//   imm     : immediate, interpretation depends on kind
//   word    : packed machine code
//   illegal : a field carried bits the layout cannot represent
module instr_field_packer
    import enc_pkg::*;
(
    input  enc_kind_t          kind,
    input  logic [OP_W-1:0]    op,
    input  logic [3:0]         ra,
    input  logic [2:0]         rb,
    input  logic [4:0]         imm,
    output logic [WORD_W-1:0]  word,
    output logic               illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        word[OP_MSB:OP_LSB] = op;
        unique case (kind)
            KindReg: begin
                word[5:3] = ra[2:0];
                word[2:0] = rb;
                // Only 8 registers are addressable in this layout.
                illegal   = ra[3];
            end
            KindAdd: begin
                word[5:2] = ra;
                word[1:0] = imm[1:0];
            end
            KindShift: begin
                word[5:4] = imm[2:1];
                word[3:1] = rb;
                word[0]   = imm[0];
            end
            KindBranch: begin
                word[5:1] = imm;
                word[0]   = rb[0];
                // Only flag selects 0/1 are encodable.
                illegal   = |rb[2:1];
            end
            default: begin
                word    = '0;
                illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loader write side: accepts field bundles over valid/ready, packs each into a
// 9-bit word and writes consecutive instruction-memory slots from start_addr.
// Ports:
//   Clk, Reset_n          : clock, asynchronous active-low reset
//   start/start_addr/num_instr : begin a session (only honoured when idle)
//   in_valid/in_ready     : bundle handshake; ready only while loading
//   in_kind..in_imm       : decoded instruction fields
//   im_we/im_addr/im_wdata: registered instruction-memory write port
//   busy                  : session in progress (load or flush)
//   done                  : one-cycle pulse after the final write
//   err                   : sticky, an illegal bundle was seen this session
module instr_encoder_loader
    import enc_pkg::*;
#(
    parameter  int unsigned DEPTH = 512,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic [AW-1:0]      start_addr,
    input  logic [AW:0]        num_instr,
    input  logic               in_valid,
    output logic               in_ready,
    input  enc_kind_t          in_kind,
    input  logic [OP_W-1:0]    in_op,
    input  logic [3:0]         in_ra,
    input  logic [2:0]         in_rb,
    input  logic [4:0]         in_imm,
    output logic               im_we,
    output logic [AW-1:0]      im_addr,
    output logic [WORD_W-1:0]  im_wdata,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [AW:0]   RemOne  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] AddrOne = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] AddrMax = AW'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [AW:0]         remaining_q, remaining_d;
    logic                we_q, we_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;

    logic [WORD_W-1:0]   packed_word;
    logic                packed_illegal;
    logic                transfer;

    instr_field_packer u_packer (
        .kind    (in_kind),
        .op      (in_op),
        .ra      (in_ra),
        .rb      (in_rb),
        .imm     (in_imm),
        .word    (packed_word),
        .illegal (packed_illegal)
    );

    // Ready is a pure decode of registered state, so there is no path from in_valid.
    assign in_ready = (state_q == StLoad);
    assign transfer = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d       = 1'b0;
                    addr_d      = start_addr;
                    remaining_d = num_instr;
                    state_d     = (num_instr == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (transfer) begin
                    we_d        = 1'b1;
                    waddr_d     = addr_q;
                    wdata_d     = packed_word;
                    err_d       = err_q | packed_illegal;
                    addr_d      = (addr_q == AddrMax) ? '0 : addr_q + AddrOne;
                    remaining_d = remaining_q - RemOne;
                    if (remaining_q == RemOne) begin
                        state_d = StFlush;
                    end
                end
            end
            // The last word is on the write port during this cycle.
            StFlush: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
        end
    end

    assign im_we    = we_q;
    assign im_addr  = waddr_q;
    assign im_wdata = wdata_q;
    assign busy     = (state_q == StLoad) || (state_q == StFlush);
    assign done     = (state_q == StDone);
    assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
    import enc_pkg::*;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              start;
    logic [AW-1:0]     start_addr;
    logic [AW:0]       num_instr;
    logic              in_valid;
    logic              in_ready;
    enc_kind_t         in_kind;
    logic [2:0]        in_op;
    logic [3:0]        in_ra;
    logic [2:0]        in_rb;
    logic [4:0]        in_imm;
    logic              im_we;
    logic [AW-1:0]     im_addr;
    logic [8:0]        im_wdata;
    logic              busy;
    logic              done;
    logic              err;

    instr_encoder_loader #(.DEPTH(DEPTH)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .start      (start),
        .start_addr (start_addr),
        .num_instr  (num_instr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_op      (in_op),
        .in_ra      (in_ra),
        .in_rb      (in_rb),
        .in_imm     (in_imm),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0] kind;
        logic [2:0] op;
        logic [3:0] ra;
        logic [2:0] rb;
        logic [4:0] imm;
        logic [8:0] word;
        bit         ill;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [8:0]    word;
        bit            err;
    } wr_t;

    vec_t vecs[$];
    wr_t  exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   err_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference packing from the field layout, using plain arithmetic.
    function automatic vec_t mk(input int kind, input int op, input int ra, input int rb,
                                input int imm);
        vec_t v;
        int   w;
        bit   ill;
        ill = 1'b0;
        case (kind)
            0: begin
                w   = op * 64 + (ra % 8) * 8 + rb;
                ill = (ra >= 8);
            end
            1: w = op * 64 + ra * 4 + imm % 4;
            2: w = op * 64 + ((imm / 2) % 4) * 16 + rb * 2 + imm % 2;
            default: begin
                w   = op * 64 + imm * 2 + rb % 2;
                ill = (rb >= 2);
            end
        endcase
        v.kind = 2'(kind);
        v.op   = 3'(op);
        v.ra   = 4'(ra);
        v.rb   = 3'(rb);
        v.imm  = 5'(imm);
        v.word = 9'(w);
        v.ill  = ill;
        return v;
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        int x;
        x = (int'(a) + 1) % DEPTH;
        return AW'(x);
    endfunction

    task automatic drive_fields(input vec_t v);
        in_kind = enc_kind_t'(v.kind);
        in_op   = v.op;
        in_ra   = v.ra;
        in_rb   = v.rb;
        in_imm  = v.imm;
    endtask

    // Write-port monitor: every write must match the next expected one.
    always @(negedge Clk) begin
        wr_t e;
        if (Reset_n === 1'b1 && im_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected write", 32'(im_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write addr", 32'(im_addr), 32'(e.addr));
                chk("write data", 32'(im_wdata), 32'(e.word));
                chk("err at write", 32'(err), 32'(e.err));
            end
        end
    end

    // Runs a full session over vecs[]; stimulus timing is bench-controlled so it always ends.
    task automatic session(input logic [AW-1:0] addr, input int pct, input bit busy_start,
                           input int stall_at, input int stall_len);
        int            n;
        int            sent;
        int            cyc;
        int            stalled;
        logic [AW-1:0] a;
        bit            v;
        n       = vecs.size();
        sent    = 0;
        cyc     = 0;
        stalled = 0;
        a       = addr;
        start      = 1'b1;
        start_addr = addr;
        num_instr  = (AW + 1)'(n);
        tick();
        start = 1'b0;
        err_m = 1'b0;
        chk("err cleared on start", 32'(err), 0);
        while (sent < n) begin
            chk("in_ready in load", 32'(in_ready), 1);
            chk("busy in load", 32'(busy), 1);
            v = ($urandom_range(99) < pct);
            if (sent == stall_at && stalled < stall_len) begin
                v = 1'b0;
                stalled++;
            end
            if (busy_start && cyc == 1) begin
                start      = 1'b1;
                start_addr = ~addr;
                num_instr  = (AW + 1)'(1);
            end else begin
                start = 1'b0;
            end
            drive_fields(vecs[sent]);
            in_valid = v;
            if (v) begin
                err_m = err_m | vecs[sent].ill;
                exp_q.push_back('{a, vecs[sent].word, err_m});
                a = next_addr(a);
                sent++;
            end
            tick();
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b1;
        chk("in_ready after last", 32'(in_ready), 0);
        chk("busy in flush", 32'(busy), 1);
        chk("done early", 32'(done), 0);
        tick();
        chk("done pulse", 32'(done), 1);
        chk("busy in done", 32'(busy), 0);
        chk("err final", 32'(err), 32'(err_m));
        tick();
        chk("done cleared", 32'(done), 0);
        chk("in_ready idle", 32'(in_ready), 0);
        in_valid = 1'b0;
        chk("writes drained", 32'(exp_q.size()), 0);
    endtask

    vec_t tbl[8];

    initial begin
        int dn;
        int bz;
        Reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        num_instr  = '0;
        in_valid   = 1'b0;
        in_kind    = KindReg;
        in_op      = '0;
        in_ra      = '0;
        in_rb      = '0;
        in_imm     = '0;

        #12;
        chk("reset im_we", 32'(im_we), 0);
        chk("reset im_addr", 32'(im_addr), 0);
        chk("reset im_wdata", 32'(im_wdata), 0);
        chk("reset in_ready", 32'(in_ready), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset err", 32'(err), 0);
        @(posedge Clk);
        #3 Reset_n = 1'b1;
        tick();

        // Table-driven layout checks: legal first, then two illegal bundles.
        tbl[0] = '{2'd0, 3'o2, 4'd5,  3'd3, 5'b00000, 9'h0AB, 1'b0};
        tbl[1] = '{2'd1, 3'o1, 4'hB,  3'd0, 5'b00010, 9'h06E, 1'b0};
        tbl[2] = '{2'd2, 3'o4, 4'd0,  3'd6, 5'b00101, 9'h12D, 1'b0};
        tbl[3] = '{2'd3, 3'o7, 4'd0,  3'd1, 5'b00011, 9'h1C7, 1'b0};
        tbl[4] = '{2'd2, 3'o0, 4'd0,  3'd0, 5'b11111, 9'h031, 1'b0};
        tbl[5] = '{2'd1, 3'o6, 4'd0,  3'd0, 5'b11111, 9'h183, 1'b0};
        tbl[6] = '{2'd3, 3'o7, 4'd0,  3'd3, 5'b00011, 9'h1C7, 1'b1};
        tbl[7] = '{2'd0, 3'o3, 4'd9,  3'd2, 5'b00000, 9'h0CA, 1'b1};
        vecs.delete();
        for (int i = 0; i < 8; i++) vecs.push_back(tbl[i]);
        session(9'h010, 100, 1'b0, -1, 0);
        chk("err sticky in idle", 32'(err), 1);

        // Valid while idle must not be taken.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        chk("err still sticky", 32'(err), 1);

        // Wrap at top of memory with a two-cycle stall mid-stream.
        vecs.delete();
        vecs.push_back(mk(0, 1, 2, 3, 0));
        vecs.push_back(mk(1, 5, 7, 0, 1));
        vecs.push_back(mk(2, 3, 0, 4, 6));
        session(AW'(DEPTH - 2), 100, 1'b0, 1, 2);

        // Zero-length session: single done pulse, never busy, no writes.
        start      = 1'b1;
        start_addr = 9'h033;
        num_instr  = '0;
        tick();
        start = 1'b0;
        dn = 0;
        bz = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dn++;
            if (busy) bz++;
            tick();
        end
        chk("zero-length done pulses", 32'(dn), 1);
        chk("zero-length busy cycles", 32'(bz), 0);

        // Reset after 2 of 4 transfers.
        vecs.delete();
        for (int i = 0; i < 4; i++) vecs.push_back(mk(i, i + 1, i, i, i + 3));
        start      = 1'b1;
        start_addr = 9'h1F0;
        num_instr  = 10'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_fields(vecs[i]);
            in_valid = 1'b1;
            exp_q.push_back('{AW'(9'h1F0 + i), vecs[i].word, 1'b0});
            tick();
        end
        #5;
        Reset_n = 1'b0;
        #1;
        chk("async rst im_we", 32'(im_we), 0);
        chk("async rst im_addr", 32'(im_addr), 0);
        chk("async rst im_wdata", 32'(im_wdata), 0);
        chk("async rst in_ready", 32'(in_ready), 0);
        chk("async rst busy", 32'(busy), 0);
        chk("async rst err", 32'(err), 0);
        chk("writes before reset", 32'(exp_q.size()), 0);
        exp_q.delete();
        tick();
        tick();
        @(posedge Clk);
        #3 Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post-reset busy", 32'(busy), 0);
            chk("post-reset in_ready", 32'(in_ready), 0);
            chk("post-reset im_we", 32'(im_we), 0);
        end
        in_valid = 1'b0;

        // Randomised sessions; the first also fires start while busy.
        for (int s = 0; s < 8; s++) begin
            int n;
            n = int'($urandom_range(1, 8));
            vecs.delete();
            for (int i = 0; i < n; i++) begin
                vecs.push_back(mk(int'($urandom_range(3)), int'($urandom_range(7)),
                                  int'($urandom_range(15)), int'($urandom_range(7)),
                                  int'($urandom_range(31))));
            end
            session((s % 2 == 0) ? AW'(DEPTH - 1 - $urandom_range(3)) : AW'($urandom_range(511)),
                    70, (s == 0), -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule
